// File: rtl/spi_leader_arbiter_pkg.sv
// Shared state encoding, defaults and sizing helpers for the SPI leader arbiter.
// Imported by the interface, picker and top.
package spi_leader_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DONE   = 2'd3
   } arb_state_e;

   localparam int DEFAULT_TIMEOUT = 1024;

   // Watchdog counter must hold TIMEOUT-1; a disabled watchdog still needs a 1-bit counter.
   function automatic int cnt_width(input int timeout);
      return (timeout > 1) ? $clog2(timeout) : 1;
   endfunction

endpackage

// File: rtl/spi_leader_arbiter_if.sv
// Requester-side and leader-side signals of the arbiter bundled into one interface.
// The arbiter uses the master view; the requesters and the attached spi_leader use the slave view.
interface spi_leader_arbiter_if #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_LEN  = 8,
   parameter int DIV_WIDTH = 8
);

   logic [NUM_REQ-1:0]           req;
   logic [NUM_REQ*DATA_LEN-1:0]  req_tx_data;
   logic [NUM_REQ*DIV_WIDTH-1:0] req_div;
   logic [NUM_REQ-1:0]           gnt;
   logic [NUM_REQ-1:0]           ack;
   logic                         err;
   logic [DATA_LEN-1:0]          rx_data;
   logic                         busy;

   logic                         spi_go;
   logic [DATA_LEN-1:0]          spi_tx_data;
   logic [DIV_WIDTH-1:0]         spi_clk_divider;
   logic [DATA_LEN-1:0]          spi_rx_data;
   logic                         spi_busy;
   logic                         spi_done;

   modport master (
      input  req, req_tx_data, req_div,
      input  spi_rx_data, spi_busy, spi_done,
      output gnt, ack, err, rx_data, busy,
      output spi_go, spi_tx_data, spi_clk_divider
   );

   modport slave (
      output req, req_tx_data, req_div,
      output spi_rx_data, spi_busy, spi_done,
      input  gnt, ack, err, rx_data, busy,
      input  spi_go, spi_tx_data, spi_clk_divider
   );

endinterface

// File: rtl/spi_leader_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request at or after the pointer,
// searching upward and wrapping modulo NUM_REQ.
module spi_rr_pick #(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   rr_ptr_i,
   output logic [NUM_REQ-1:0] winner_o,
   output logic [IDX_W-1:0]   winner_idx_o
);

   always_comb begin
      logic [IDX_W-1:0] cand;
      logic             found;
      winner_o     = '0;
      winner_idx_o = '0;
      found        = 1'b0;
      cand         = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = IDX_W'((int'(rr_ptr_i) + k) % NUM_REQ);
         if (!found && req_i[cand]) begin
            found          = 1'b1;
            winner_o[cand] = 1'b1;
            winner_idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/spi_leader_arbiter.sv
// Shares one spi_leader between NUM_REQ requesters: round-robin grant, launch, wait for
// done (or watchdog abort), then a one-cycle ack carrying the received word.
module spi_leader_arbiter
   import spi_leader_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_LEN  = 8,
   parameter int DIV_WIDTH = 8,
   parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
   input logic                  sys_clk,
   input logic                  rst_n,
   spi_leader_arbiter_if.master bus
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = cnt_width(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   arb_state_e           state_q, state_d;
   logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]     win_q, win_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 first_wait_q, first_wait_d;
   logic                 err_q, err_d;
   logic [DATA_LEN-1:0]  rx_q, rx_d;
   logic [DATA_LEN-1:0]  tx_q, tx_d;
   logic [DIV_WIDTH-1:0] div_q, div_d;

   logic [NUM_REQ-1:0]   pick_onehot;
   logic [IDX_W-1:0]     pick_idx;
   logic [DATA_LEN-1:0]  pick_tx;
   logic [DIV_WIDTH-1:0] pick_div;
   logic [NUM_REQ-1:0]   win_onehot;
   logic [IDX_W-1:0]     rr_next;
   logic                 done_seen;
   logic                 timed_out;

   spi_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req_i        (bus.req),
      .rr_ptr_i     (rr_ptr_q),
      .winner_o     (pick_onehot),
      .winner_idx_o (pick_idx)
   );

   assign pick_tx  = bus.req_tx_data[pick_idx*DATA_LEN +: DATA_LEN];
   assign pick_div = bus.req_div[pick_idx*DIV_WIDTH +: DIV_WIDTH];
   assign rr_next  = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;

   // A done level left over from the previous transfer is masked in the first WAIT cycle.
   assign done_seen = bus.spi_done && !first_wait_q;
   assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         rr_ptr_q     <= '0;
         win_q        <= '0;
         cnt_q        <= '0;
         first_wait_q <= 1'b0;
         err_q        <= 1'b0;
         rx_q         <= '0;
         tx_q         <= '0;
         div_q        <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         win_q        <= win_d;
         cnt_q        <= cnt_d;
         first_wait_q <= first_wait_d;
         err_q        <= err_d;
         rx_q         <= rx_d;
         tx_q         <= tx_d;
         div_q        <= div_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      win_d        = win_q;
      cnt_d        = cnt_q;
      first_wait_d = first_wait_q;
      err_d        = err_q;
      rx_d         = rx_q;
      tx_d         = tx_q;
      div_d        = div_q;
      unique case (state_q)
         ST_IDLE: begin
            // Leader still busy (e.g. after an abort) blocks new grants.
            if ((|pick_onehot) && !bus.spi_busy) begin
               state_d = ST_LAUNCH;
               win_d   = pick_idx;
               tx_d    = pick_tx;
               div_d   = (pick_div == '0) ? DIV_WIDTH'(1) : pick_div;
            end
         end
         ST_LAUNCH: begin
            state_d      = ST_WAIT;
            cnt_d        = '0;
            first_wait_d = 1'b1;
         end
         ST_WAIT: begin
            first_wait_d = 1'b0;
            if (done_seen) begin
               state_d = ST_DONE;
               rx_d    = bus.spi_rx_data;
               err_d   = 1'b0;
            end else if (timed_out) begin
               state_d = ST_DONE;
               rx_d    = '0;
               err_d   = 1'b1;
            end else if (TIMEOUT != 0) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_d  = ST_IDLE;
            rr_ptr_d = rr_next;
            err_d    = 1'b0;
         end
      endcase
   end

   always_comb begin
      win_onehot        = '0;
      win_onehot[win_q] = 1'b1;
   end

   assign bus.gnt             = (state_q != ST_IDLE) ? win_onehot : '0;
   assign bus.ack             = (state_q == ST_DONE) ? win_onehot : '0;
   assign bus.spi_go          = (state_q == ST_LAUNCH);
   assign bus.busy            = (state_q != ST_IDLE);
   assign bus.err             = err_q;
   assign bus.rx_data         = rx_q;
   assign bus.spi_tx_data     = tx_q;
   assign bus.spi_clk_divider = div_q;

   a_gnt_onehot : assert property (@(posedge sys_clk) disable iff (!rst_n) $onehot0(bus.gnt));
   a_ack_onehot : assert property (@(posedge sys_clk) disable iff (!rst_n) $onehot0(bus.ack));

endmodule

// File: tb/tb_spi_leader_arbiter.sv
// Directed bench for spi_leader_arbiter; a small behavioural leader/follower stands in
// for spi_leader + spi_follower and answers each go after a short fixed transfer.
module tb_spi_leader_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int DATA_LEN  = 8;
   localparam int DIV_WIDTH = 8;
   localparam int TIMEOUT   = 16;

   logic sys_clk = 1'b0;
   logic rst_n   = 1'b0;

   int total = 0;
   int bad   = 0;

   int goCount  = 0;
   int ackCount = 0;
   int gntViol  = 0;
   int ackViol  = 0;

   logic                 hangMode     = 1'b0;
   logic                 leaderAbort  = 1'b0;
   logic                 leaderEcho   = 1'b0;
   logic [DATA_LEN-1:0]  followerWord = '0;
   logic                 mBusy        = 1'b0;
   logic                 mDone        = 1'b0;
   logic [2:0]           mLeft        = '0;
   logic [DATA_LEN-1:0]  mRx          = '0;
   logic [DATA_LEN-1:0]  mSeenTx      = '0;
   logic [DIV_WIDTH-1:0] mSeenDiv     = '0;

   spi_leader_arbiter_if #(
      .NUM_REQ   (NUM_REQ),
      .DATA_LEN  (DATA_LEN),
      .DIV_WIDTH (DIV_WIDTH)
   ) arbBus ();

   spi_leader_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .DATA_LEN  (DATA_LEN),
      .DIV_WIDTH (DIV_WIDTH),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .bus     (arbBus)
   );

   always #5 sys_clk = ~sys_clk;

   // Leader stand-in: busy from go, done pulse after a few cycles, or hangs until aborted.
   always @(posedge sys_clk) begin
      if (!rst_n) begin
         mBusy <= 1'b0;
         mDone <= 1'b0;
         mLeft <= '0;
      end else if (arbBus.spi_go) begin
         mBusy    <= 1'b1;
         mDone    <= 1'b0;
         mLeft    <= 3'd3;
         mSeenTx  <= arbBus.spi_tx_data;
         mSeenDiv <= arbBus.spi_clk_divider;
      end else if (mDone) begin
         mDone <= 1'b0;
         mBusy <= 1'b0;
      end else if (mBusy) begin
         if (leaderAbort) begin
            mBusy <= 1'b0;
         end else if (!hangMode) begin
            if (mLeft == 3'd0) begin
               mDone <= 1'b1;
               mRx   <= leaderEcho ? ~mSeenTx : followerWord;
            end else begin
               mLeft <= mLeft - 3'd1;
            end
         end
      end
   end

   assign arbBus.spi_busy    = mBusy;
   assign arbBus.spi_done    = mDone;
   assign arbBus.spi_rx_data = mRx;

   always @(negedge sys_clk) begin
      if (rst_n) begin
         if (arbBus.spi_go === 1'b1) goCount++;
         if (arbBus.ack !== '0) ackCount++;
         if (!$onehot0(arbBus.gnt)) gntViol++;
         if (!$onehot0(arbBus.ack) || ((arbBus.ack & ~arbBus.gnt) !== '0)) ackViol++;
      end
   end

   task automatic wait_for_go(input int limit, output bit seen);
      seen = 1'b0;
      for (int c = 0; c < limit && !seen; c++) begin
         @(negedge sys_clk);
         if (arbBus.spi_go === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic wait_for_ack(input int limit, output bit seen, output int cycles);
      seen   = 1'b0;
      cycles = 0;
      while (!seen && cycles < limit) begin
         @(negedge sys_clk);
         cycles++;
         if (arbBus.ack !== '0) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge sys_clk);
      total++;
      if (arbBus.gnt !== 4'b0000 || arbBus.ack !== 4'b0000) begin
         bad++;
         $display("[TB] FAIL reset_gnt_ack gnt=%b ack=%b required 0000/0000", arbBus.gnt, arbBus.ack);
      end
      total++;
      if (arbBus.busy !== 1'b0 || arbBus.spi_go !== 1'b0 || arbBus.err !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_flags busy=%b go=%b err=%b required 0/0/0", arbBus.busy, arbBus.spi_go, arbBus.err);
      end
      total++;
      if (arbBus.spi_tx_data !== 8'h00 || arbBus.spi_clk_divider !== 8'h00 || arbBus.rx_data !== 8'h00) begin
         bad++;
         $display("[TB] FAIL reset_data tx=%h div=%h rx=%h required 00/00/00",
                  arbBus.spi_tx_data, arbBus.spi_clk_divider, arbBus.rx_data);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);
      total++;
      if (arbBus.busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_idle busy=%b required 0", arbBus.busy);
      end
   endtask

   task automatic test_single_requester();
      int goStart;
      int cycles;
      bit seen;
      arbBus.req_tx_data[7:0] = 8'hA5;
      arbBus.req_div[7:0]     = 8'd4;
      followerWord            = 8'h3C;
      leaderEcho              = 1'b0;
      goStart                 = goCount;
      arbBus.req              = 4'b0001;
      @(negedge sys_clk);
      total++;
      if (arbBus.spi_go !== 1'b1 || arbBus.gnt !== 4'b0001) begin
         bad++;
         $display("[TB] FAIL single_launch go=%b gnt=%b required 1/0001", arbBus.spi_go, arbBus.gnt);
      end
      total++;
      if (arbBus.spi_tx_data !== 8'hA5 || arbBus.spi_clk_divider !== 8'd4) begin
         bad++;
         $display("[TB] FAIL single_launch_data tx=%h div=%0d required a5/4", arbBus.spi_tx_data, arbBus.spi_clk_divider);
      end
      wait_for_ack(40, seen, cycles);
      total++;
      if (!seen || arbBus.ack !== 4'b0001) begin
         bad++;
         $display("[TB] FAIL single_ack ack=%b seen=%0d required 0001", arbBus.ack, seen);
      end
      total++;
      if (arbBus.rx_data !== 8'h3C || arbBus.err !== 1'b0) begin
         bad++;
         $display("[TB] FAIL single_rx rx=%h err=%b required 3c/0", arbBus.rx_data, arbBus.err);
      end
      total++;
      if (mSeenTx !== 8'hA5) begin
         bad++;
         $display("[TB] FAIL single_follower_rx got=%h required a5", mSeenTx);
      end
      arbBus.req = 4'b0000;
      repeat (4) @(negedge sys_clk);
      total++;
      if (goCount - goStart !== 1) begin
         bad++;
         $display("[TB] FAIL single_go_count got=%0d required 1", goCount - goStart);
      end
      total++;
      if (arbBus.busy !== 1'b0 || arbBus.rx_data !== 8'h3C) begin
         bad++;
         $display("[TB] FAIL single_after busy=%b rx=%h required 0/3c", arbBus.busy, arbBus.rx_data);
      end
   endtask

   task automatic test_round_robin();
      int order[5] = '{0, 1, 2, 3, 0};
      logic [DATA_LEN-1:0] txTab[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      logic [3:0] expAck;
      logic [DATA_LEN-1:0] expRx;
      int cycles;
      bit seen;
      rst_n = 1'b0;
      @(negedge sys_clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         arbBus.req_tx_data[i*8 +: 8] = txTab[i];
         arbBus.req_div[i*8 +: 8]     = 8'd2;
      end
      leaderEcho = 1'b1;
      arbBus.req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         expAck = 4'b0001 << order[i];
         expRx  = ~txTab[order[i]];
         wait_for_ack(60, seen, cycles);
         total++;
         if (!seen || arbBus.ack !== expAck || arbBus.gnt !== expAck) begin
            bad++;
            $display("[TB] FAIL rr_ack[%0d] ack=%b gnt=%b required %b", i, arbBus.ack, arbBus.gnt, expAck);
         end
         total++;
         if (arbBus.rx_data !== expRx || arbBus.err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rr_rx[%0d] rx=%h err=%b required %h/0", i, arbBus.rx_data, arbBus.err, expRx);
         end
      end
      arbBus.req = 4'b0000;
      repeat (3) @(negedge sys_clk);
   endtask

   task automatic test_fairness();
      logic [3:0] reqSeq[4] = '{4'b0010, 4'b1001, 4'b0001, 4'b0011};
      logic [3:0] expSeq[4] = '{4'b0010, 4'b1000, 4'b0001, 4'b0010};
      int cycles;
      bit seen;
      // Pointer is 1 here; granting requester 1 first moves it to 2.
      arbBus.req = reqSeq[0];
      for (int i = 0; i < 4; i++) begin
         wait_for_ack(60, seen, cycles);
         total++;
         if (!seen || arbBus.ack !== expSeq[i]) begin
            bad++;
            $display("[TB] FAIL fair_ack[%0d] ack=%b required %b", i, arbBus.ack, expSeq[i]);
         end
         arbBus.req = (i < 3) ? reqSeq[i+1] : 4'b0000;
      end
      leaderEcho = 1'b0;
      repeat (3) @(negedge sys_clk);
   endtask

   task automatic test_timeout();
      int goStart;
      int cycles;
      bit seen;
      hangMode                  = 1'b1;
      arbBus.req_tx_data[23:16] = 8'h5A;
      arbBus.req_div[23:16]     = 8'd3;
      arbBus.req                = 4'b0100;
      wait_for_go(10, seen);
      total++;
      if (!seen) begin
         bad++;
         $display("[TB] FAIL timeout_go go=%b required 1", arbBus.spi_go);
      end
      // LAUNCH, 16 WAIT cycles, then DONE: ack 17 edges after the go cycle.
      wait_for_ack(40, seen, cycles);
      total++;
      if (!seen || cycles !== 17) begin
         bad++;
         $display("[TB] FAIL timeout_latency cycles=%0d seen=%0d required 17", cycles, seen);
      end
      total++;
      if (arbBus.ack !== 4'b0100 || arbBus.err !== 1'b1 || arbBus.rx_data !== 8'h00) begin
         bad++;
         $display("[TB] FAIL timeout_abort ack=%b err=%b rx=%h required 0100/1/00", arbBus.ack, arbBus.err, arbBus.rx_data);
      end
      goStart                 = goCount;
      followerWord            = 8'h77;
      arbBus.req_tx_data[7:0] = 8'h96;
      arbBus.req_div[7:0]     = 8'd2;
      arbBus.req              = 4'b0001;
      repeat (6) @(negedge sys_clk);
      total++;
      if (arbBus.gnt !== 4'b0000 || arbBus.busy !== 1'b0 || arbBus.err !== 1'b0) begin
         bad++;
         $display("[TB] FAIL timeout_hold gnt=%b busy=%b err=%b required 0000/0/0", arbBus.gnt, arbBus.busy, arbBus.err);
      end
      total++;
      if (goCount !== goStart) begin
         bad++;
         $display("[TB] FAIL timeout_no_go extra_go=%0d required 0", goCount - goStart);
      end
      hangMode    = 1'b0;
      leaderAbort = 1'b1;
      @(negedge sys_clk);
      leaderAbort = 1'b0;
      wait_for_ack(40, seen, cycles);
      total++;
      if (!seen || arbBus.ack !== 4'b0001 || arbBus.err !== 1'b0 || arbBus.rx_data !== 8'h77) begin
         bad++;
         $display("[TB] FAIL timeout_recover ack=%b err=%b rx=%h required 0001/0/77", arbBus.ack, arbBus.err, arbBus.rx_data);
      end
      arbBus.req = 4'b0000;
      repeat (3) @(negedge sys_clk);
   endtask

   task automatic test_reset_mid_wait();
      int ackBefore;
      int cycles;
      bit seen;
      hangMode                = 1'b1;
      arbBus.req_tx_data[7:0] = 8'hE1;
      arbBus.req              = 4'b0001;
      wait_for_go(10, seen);
      repeat (3) @(negedge sys_clk);
      total++;
      if (!seen || arbBus.busy !== 1'b1 || arbBus.gnt !== 4'b0001 || arbBus.spi_go !== 1'b0) begin
         bad++;
         $display("[TB] FAIL rst_pre_wait busy=%b gnt=%b go=%b required 1/0001/0", arbBus.busy, arbBus.gnt, arbBus.spi_go);
      end
      ackBefore  = ackCount;
      rst_n      = 1'b0;
      arbBus.req = 4'b0000;
      @(negedge sys_clk);
      total++;
      if (arbBus.gnt !== 4'b0000 || arbBus.ack !== 4'b0000 || arbBus.busy !== 1'b0 ||
          arbBus.spi_go !== 1'b0 || arbBus.err !== 1'b0) begin
         bad++;
         $display("[TB] FAIL rst_mid_ctrl gnt=%b ack=%b busy=%b go=%b err=%b required all 0",
                  arbBus.gnt, arbBus.ack, arbBus.busy, arbBus.spi_go, arbBus.err);
      end
      total++;
      if (arbBus.spi_tx_data !== 8'h00 || arbBus.spi_clk_divider !== 8'h00 || arbBus.rx_data !== 8'h00) begin
         bad++;
         $display("[TB] FAIL rst_mid_data tx=%h div=%h rx=%h required 00/00/00",
                  arbBus.spi_tx_data, arbBus.spi_clk_divider, arbBus.rx_data);
      end
      rst_n    = 1'b1;
      hangMode = 1'b0;
      repeat (3) @(negedge sys_clk);
      total++;
      if (ackCount !== ackBefore) begin
         bad++;
         $display("[TB] FAIL rst_no_ack acks=%0d required 0", ackCount - ackBefore);
      end
      // Pointer was 1 before reset; restarting at 0 picks requester 0 out of 0011.
      arbBus.req = 4'b0011;
      wait_for_go(10, seen);
      total++;
      if (!seen || arbBus.gnt !== 4'b0001) begin
         bad++;
         $display("[TB] FAIL rst_restart gnt=%b seen=%0d required 0001", arbBus.gnt, seen);
      end
      wait_for_ack(40, seen, cycles);
      arbBus.req = 4'b0000;
      total++;
      if (!seen || arbBus.ack !== 4'b0001) begin
         bad++;
         $display("[TB] FAIL rst_restart_ack ack=%b required 0001", arbBus.ack);
      end
      repeat (3) @(negedge sys_clk);
   endtask

   task automatic test_div_zero();
      int cycles;
      bit seen;
      arbBus.req_tx_data[15:8] = 8'hC3;
      arbBus.req_div[15:8]     = 8'd0;
      followerWord             = 8'h5E;
      arbBus.req               = 4'b0010;
      wait_for_go(10, seen);
      total++;
      if (!seen || arbBus.spi_clk_divider !== 8'd1 || arbBus.spi_tx_data !== 8'hC3) begin
         bad++;
         $display("[TB] FAIL div0_launch div=%0d tx=%h required 1/c3", arbBus.spi_clk_divider, arbBus.spi_tx_data);
      end
      repeat (2) @(negedge sys_clk);
      total++;
      if (arbBus.spi_clk_divider !== 8'd1 || arbBus.spi_tx_data !== 8'hC3) begin
         bad++;
         $display("[TB] FAIL div0_hold div=%0d tx=%h required 1/c3", arbBus.spi_clk_divider, arbBus.spi_tx_data);
      end
      wait_for_ack(40, seen, cycles);
      total++;
      if (!seen || arbBus.ack !== 4'b0010 || arbBus.rx_data !== 8'h5E || arbBus.err !== 1'b0) begin
         bad++;
         $display("[TB] FAIL div0_ack ack=%b rx=%h err=%b required 0010/5e/0", arbBus.ack, arbBus.rx_data, arbBus.err);
      end
      total++;
      if (mSeenTx !== 8'hC3 || mSeenDiv !== 8'd1) begin
         bad++;
         $display("[TB] FAIL div0_leader tx=%h div=%0d required c3/1", mSeenTx, mSeenDiv);
      end
      arbBus.req = 4'b0000;
      repeat (3) @(negedge sys_clk);
   endtask

   initial begin
      arbBus.req         = '0;
      arbBus.req_tx_data = '0;
      arbBus.req_div     = '0;
      test_reset();
      test_single_requester();
      test_round_robin();
      test_fairness();
      test_timeout();
      test_reset_mid_wait();
      test_div_zero();
      total++;
      if (gntViol !== 0 || ackViol !== 0) begin
         bad++;
         $display("[TB] FAIL onehot gnt_viol=%0d ack_viol=%0d required 0/0", gntViol, ackViol);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
